// File: rtl/jtframe_dwnld_pkg.sv
// Shared definitions for the ROM download consumer: FSM states, byte-mask codes,
// fill byte and the word-packing helper.
package jtframe_dwnld_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // prog_mask is active-low: bit 0 enables the low byte lane, bit 1 the high lane
  localparam logic [1:0] MASK_FULL = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Returns {mask, data}; a swap moves the even byte to [15:8] and swaps the lanes of the mask
  function automatic logic [17:0] pack_word(input logic [7:0] lo, input logic [7:0] hi,
                                            input logic [1:0] mask, input logic swab);
    if (swab) return {mask[0], mask[1], lo, hi};
    else      return {mask, hi, lo};
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// First-word-fall-through word FIFO with two ordered push ports and one pop port.
// A push that finds no free slot is dropped and flagged on drop.
module jtframe_dwnld_fifo #(
  parameter int unsigned DW = 39,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_a,
  input  logic [DW-1:0] din_a,
  input  logic          push_b,
  input  logic [DW-1:0] din_b,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          drop
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, used, wr_b;
  logic          full, acc_a, acc_b;

  assign used  = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Free space is judged before this cycle's pop, so a full FIFO never accepts a word
  assign acc_a = push_a && !full;
  assign acc_b = push_b && (acc_a ? (used < (AW+1)'(DEPTH-1)) : !full);
  assign wr_b  = wr_ptr + (AW+1)'(acc_a);
  assign drop  = (push_a && !acc_a) || (push_b && !acc_b);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (acc_a) mem[wr_ptr[AW-1:0]] <= din_a;
    if (acc_b) mem[wr_b[AW-1:0]]   <= din_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(acc_a) + (AW+1)'(acc_b);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/jtframe_unamiga_dwnld.sv
// ioctl byte stream to SDRAM programming port: packs bytes into 16-bit words,
// buffers them and writes them out with a we/rdy handshake, reporting busy/done.
module jtframe_unamiga_dwnld
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW      = 22,
  parameter int FIFO_AW = 2,
  parameter int SWAB    = 0
) (
  input  logic          clk_rom,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-2:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          dwnld_busy,
  output logic          dwnld_done,
  output logic          ovf
);

  localparam int   WW   = AW + 17;  // {addr, mask, data}
  localparam logic SWAP = (SWAB != 0);

  state_t          state, state_nx;
  logic            dl_q, rise, fall, byte_ev, to_done;
  logic            pend_valid, pend_set, pend_clr;
  logic [AW-2:0]   pend_addr, word_addr;
  logic [7:0]      pend_data;
  logic            push_a, push_b, fifo_pop, fifo_empty, fifo_drop, load;
  logic [WW-1:0]   word_a, word_b, fifo_dout, partial_w, lone_w, full_w;

  assign rise      = downloading && !dl_q;
  assign fall      = !downloading && dl_q;
  assign byte_ev   = ioctl_wr && downloading;
  assign word_addr = ioctl_addr[AW-1:1];

  assign partial_w = {pend_addr, pack_word(pend_data, FILL_BYTE, MASK_LO, SWAP)};
  assign lone_w    = {word_addr, pack_word(FILL_BYTE, ioctl_data, MASK_HI, SWAP)};
  assign full_w    = {word_addr, pack_word(pend_data, ioctl_data, MASK_FULL, SWAP)};

  // An odd byte landing on a foreign word needs two pushes: the stale half word, then itself
  always_comb begin
    push_a   = 1'b0;
    push_b   = 1'b0;
    word_a   = partial_w;
    word_b   = lone_w;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    if (byte_ev) begin
      if (ioctl_addr[0]) begin
        pend_clr = 1'b1;
        push_a   = 1'b1;
        if (pend_valid && pend_addr == word_addr) begin
          word_a = full_w;
        end else begin
          word_a = pend_valid ? partial_w : lone_w;
          push_b = pend_valid;
        end
      end else begin
        pend_set = 1'b1;
        push_a   = pend_valid && (pend_addr != word_addr);
      end
    end else if (!downloading && pend_valid) begin
      push_a   = 1'b1;
      pend_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else if (pend_set) begin
      pend_valid <= 1'b1;
      pend_addr  <= word_addr;
      pend_data  <= ioctl_data;
    end else if (pend_clr) begin
      pend_valid <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    to_done  = 1'b0;
    case (state)
      ST_IDLE:  if (rise) state_nx = ST_LOAD;
      ST_LOAD:  if (fall) state_nx = ST_FLUSH;
      ST_FLUSH: if (fifo_empty && !prog_we) begin
                  if (downloading) state_nx = ST_LOAD;
                  else begin
                    state_nx = ST_DONE;
                    to_done  = 1'b1;
                  end
                end
      ST_DONE:  state_nx = rise ? ST_LOAD : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state      <= ST_IDLE;
      dl_q       <= 1'b0;
      dwnld_busy <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nx;
      dl_q       <= downloading;
      dwnld_busy <= (dwnld_busy && !to_done) || byte_ev;
      ovf        <= (ovf && !rise) || fifo_drop;
    end
  end

  assign dwnld_done = (state == ST_DONE);

  // The head word leaves the FIFO as it is latched into prog_*, so the output
  // register acts as one extra slot in front of the FIFO
  assign load     = !prog_we && !fifo_empty;
  assign fifo_pop = load;

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= MASK_NONE;
    end else if (prog_we && prog_rdy) begin
      prog_we <= 1'b0;
    end else if (load) begin
      prog_we <= 1'b1;
      {prog_addr, prog_mask, prog_data} <= fifo_dout;
    end
  end

  jtframe_dwnld_fifo #(
    .DW (WW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk    (clk_rom),
    .rst    (rst),
    .push_a (push_a),
    .din_a  (word_a),
    .push_b (push_b),
    .din_b  (word_b),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

endmodule

// File: tb/tb_jtframe_unamiga_dwnld.sv
// Bench for jtframe_unamiga_dwnld: directed vector table, corner-case sequences and
// randomized downloads checked every cycle against a queue-based reference model.
module tb_jtframe_unamiga_dwnld;

  logic        clk = 1'b0;
  logic        rst, downloading, ioctl_wr, prog_rdy;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [20:0] prog_addr, s_addr;
  logic [15:0] prog_data, s_data;
  logic [1:0]  prog_mask, s_mask;
  logic        prog_we, dwnld_busy, dwnld_done, ovf;
  logic        s_we, s_busy, s_done, s_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_unamiga_dwnld #(.AW(22), .FIFO_AW(2), .SWAB(0)) dut (
    .clk_rom(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .dwnld_busy(dwnld_busy), .dwnld_done(dwnld_done), .ovf(ovf));

  jtframe_unamiga_dwnld #(.AW(22), .FIFO_AW(2), .SWAB(1)) dut_swab (
    .clk_rom(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prog_addr(s_addr),
    .prog_data(s_data), .prog_mask(s_mask), .prog_we(s_we), .prog_rdy(prog_rdy),
    .dwnld_busy(s_busy), .dwnld_done(s_done), .ovf(s_ovf));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pending byte, word queue of depth 4, one output register
  typedef struct packed { logic [20:0] a; logic [15:0] d; logic [1:0] m; } wrd_t;
  bit          m_dlp, m_pv, m_we, m_busy, m_done, m_ovf;
  int          m_ph;  // 0 idle, 1 loading, 2 flushing, 3 done
  logic [20:0] m_pa;
  logic [7:0]  m_pd;
  wrd_t        m_q[$];
  wrd_t        m_reg;

  task automatic model_step();
    wrd_t        pushes[$];
    wrd_t        part;
    bit          rise, fall, bev, pop, drop, drained, to_done;
    int          space, nxt;
    logic [20:0] wa;
    if (rst) begin
      m_dlp = 0; m_ph = 0; m_pv = 0; m_we = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      m_q.delete();
      m_reg = '{a: 21'h0, d: 16'h0, m: 2'b11};
      return;
    end
    rise = downloading && !m_dlp;
    fall = !downloading && m_dlp;
    bev  = ioctl_wr && downloading;
    wa   = ioctl_addr[21:1];
    part = '{a: m_pa, d: {8'hFF, m_pd}, m: 2'b10};
    if (bev && ioctl_addr[0]) begin
      if (m_pv && m_pa == wa) pushes.push_back('{a: wa, d: {ioctl_data, m_pd}, m: 2'b00});
      else begin
        if (m_pv) pushes.push_back(part);
        pushes.push_back('{a: wa, d: {ioctl_data, 8'hFF}, m: 2'b01});
      end
      m_pv = 0;
    end else if (bev) begin
      if (m_pv && m_pa != wa) pushes.push_back(part);
      m_pv = 1; m_pa = wa; m_pd = ioctl_data;
    end else if (!downloading && m_pv) begin
      pushes.push_back(part);
      m_pv = 0;
    end
    drained = (m_q.size() == 0) && !m_we;
    pop = 0;
    if (m_we && prog_rdy) m_we = 0;
    else if (!m_we && m_q.size() > 0) begin
      m_reg = m_q[0]; m_we = 1; pop = 1;
    end
    space = 4 - m_q.size();
    drop = 0;
    foreach (pushes[i]) begin
      if (space > 0) begin m_q.push_back(pushes[i]); space--; end
      else drop = 1;
    end
    if (pop) void'(m_q.pop_front());
    nxt = m_ph; to_done = 0;
    case (m_ph)
      0: if (rise) nxt = 1;
      1: if (fall) nxt = 2;
      2: if (drained) begin
           if (downloading) nxt = 1;
           else begin nxt = 3; to_done = 1; end
         end
      default: nxt = rise ? 1 : 0;
    endcase
    m_ph   = nxt;
    m_done = (nxt == 3);
    m_busy = (m_busy && !to_done) || bev;
    m_ovf  = (m_ovf && !rise) || drop;
    m_dlp  = downloading;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("model", {prog_we, prog_addr, prog_data, prog_mask, dwnld_busy, dwnld_done, ovf},
          {m_we, m_reg, m_busy, m_done, m_ovf});
  end

  task automatic cyc(input logic dl, input logic wr, input logic [21:0] a,
                     input logic [7:0] d, input logic rdy);
    @(negedge clk);
    downloading = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_data = d; prog_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic dl, wr; logic [21:0] a; logic [7:0] d; logic rdy;
    logic we; logic [20:0] pa; logic [15:0] pd; logic [1:0] pm; logic busy, done;
  } vec_t;
  vec_t tbl[24];

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [20:0] got_a[$];
    logic [15:0] got_d[$];
    bit          seen;
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0; prog_rdy = 1'b0;

    //          dl    wr    addr    data   rdy  | we    paddr   pdata     mask   busy  done
    tbl[0]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h0, 16'h0000, 2'b11, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 22'h0, 8'h11, 1'b0, 1'b0, 21'h0, 16'h0000, 2'b11, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 22'h1, 8'h22, 1'b0, 1'b0, 21'h0, 16'h0000, 2'b11, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, 1'b1, 21'h0, 16'h2211, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, 1'b1, 21'h0, 16'h2211, 2'b00, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, 1'b1, 21'h0, 16'h2211, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0, 21'h0, 16'h2211, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 22'h4, 8'hAB, 1'b0, 1'b0, 21'h0, 16'h2211, 2'b00, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h0, 16'h2211, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b1, 21'h2, 16'hFFAB, 2'b10, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0, 21'h2, 16'hFFAB, 2'b10, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h2, 16'hFFAB, 2'b10, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h2, 16'hFFAB, 2'b10, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h2, 16'hFFAB, 2'b10, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 22'h7, 8'h5A, 1'b0, 1'b0, 21'h2, 16'hFFAB, 2'b10, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 22'h8, 8'h01, 1'b0, 1'b1, 21'h3, 16'h5AFF, 2'b01, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 22'hA, 8'h02, 1'b1, 1'b0, 21'h3, 16'h5AFF, 2'b01, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b0, 1'b1, 21'h4, 16'hFF01, 2'b10, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0, 21'h4, 16'hFF01, 2'b10, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h4, 16'hFF01, 2'b10, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b1, 21'h5, 16'hFF02, 2'b10, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b1, 1'b0, 21'h5, 16'hFF02, 2'b10, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h5, 16'hFF02, 2'b10, 1'b0, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 22'h0, 8'h00, 1'b0, 1'b0, 21'h5, 16'hFF02, 2'b10, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_we", prog_we, 1'b0);
    check("reset_mask", prog_mask, 2'b11);
    check("reset_addr_data", {prog_addr, prog_data}, 37'h0);
    check("reset_flags", {dwnld_busy, dwnld_done, ovf}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].dl, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rdy);
      check($sformatf("row%0d", i), {prog_we, prog_addr, prog_data, prog_mask, dwnld_busy, dwnld_done},
            {tbl[i].we, tbl[i].pa, tbl[i].pd, tbl[i].pm, tbl[i].busy, tbl[i].done});
      check($sformatf("swab_row%0d", i), s_data, {tbl[i].pd[7:0], tbl[i].pd[15:8]});
    end

    // Overflow: rdy held low while six words stream in
    cyc(1'b1, 1'b0, 22'h0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 22'h40 + 22'(i), 8'h30 + 8'(i), 1'b0);
    cyc(1'b1, 1'b0, 22'h0, 8'h00, 1'b0);
    check("ovf_hold_we_addr", {prog_we, prog_addr, prog_data}, {1'b1, 21'h20, 16'h3130});
    check("ovf_set", ovf, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      prog_rdy = 1'b1;
      if (prog_we) begin got_a.push_back(prog_addr); got_d.push_back(prog_data); end
      @(posedge clk);
      #1;
    end
    check("ovf_write_count", got_a.size(), 5);
    foreach (got_a[k]) begin
      check($sformatf("ovf_wr%0d_addr", k), got_a[k], 21'h20 + 21'(k));
      check($sformatf("ovf_wr%0d_data", k), got_d[k], {8'h31 + 8'(2*k), 8'h30 + 8'(2*k)});
    end
    check("ovf_sticky", ovf, 1'b1);
    repeat (6) cyc(1'b0, 1'b0, 22'h0, 8'h00, 1'b0);

    // Reset with a write pending and three words queued, then restart
    cyc(1'b1, 1'b0, 22'h0, 8'h00, 1'b0);
    check("ovf_cleared_new_dl", ovf, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 22'h200 + 22'(i), 8'h70 + 8'(i), 1'b0);
    cyc(1'b1, 1'b0, 22'h0, 8'h00, 1'b0);
    check("pre_rst_we", {prog_we, prog_addr}, {1'b1, 21'h100});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_we_busy_done", {prog_we, dwnld_busy, dwnld_done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 22'h0, 8'h00, 1'b0);
    check("rst_no_done", {prog_we, dwnld_done}, 2'b00);
    cyc(1'b1, 1'b0, 22'h0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 22'h300, 8'hC1, 1'b1);
    cyc(1'b1, 1'b1, 22'h301, 8'hC2, 1'b1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (prog_we) begin
        seen = 1;
        check("restart_first_write", {prog_addr, prog_data, prog_mask}, {21'h180, 16'hC2C1, 2'b00});
      end else cyc(1'b1, 1'b0, 22'h0, 8'h00, 1'b1);
    end
    if (!seen) check("restart_write_seen", 1'b0, 1'b1);
    repeat (8) cyc(1'b0, 1'b0, 22'h0, 8'h00, 1'b1);

    // Randomized downloads against the model
    for (int n = 0; n < 40; n++) begin
      logic [21:0] a;
      int          len, thr, gap;
      a   = 22'($urandom_range(0, 32'h3FFF00));
      len = $urandom_range(1, 40);
      thr = $urandom_range(1, 4);
      cyc(1'b1, 1'b0, a, 8'h00, 1'($urandom_range(0, 1)));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          cyc(1'b1, 1'b1, a, 8'($urandom), 1'($urandom_range(0, 3) < thr));
          a = a + (($urandom_range(0, 7) == 0) ? 22'($urandom_range(2, 5)) : 22'd1);
        end else cyc(1'b1, 1'b0, a, 8'($urandom), 1'($urandom_range(0, 3) < thr));
      end
      gap = $urandom_range(0, 15);
      for (int k = 0; k < gap; k++) cyc(1'b0, 1'b0, a, 8'h00, 1'($urandom_range(0, 1)));
    end
    repeat (30) cyc(1'b0, 1'b0, 22'h0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
